// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction-fetch and request sequencer for the
// single-issue MIPS datapath. Owns the PC, fetches into a held Instr register,
// selects the next PC from decoded controls and holds data-memory requests
// until acknowledged.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   ihit, imemload      instruction memory response
//   dhit                data memory completion
//   PCSrc, Jmp, JAL, JR decoded control-flow controls
//   HALT, MemRd, MemWr  decoded halt / load / store
//   imm16, imm26        branch offset, jump target field
//   rs_data             JR target
//   imemREN, imemaddr   instruction read request / address (= PC)
//   dmemREN, dmemWEN    data read / write requests
//   Instr, instr_valid  latched instruction and its validity
//   pc4                 PC+4 (JAL link value)
//   commit              one-cycle register-file write enable pulse
//   halt                sticky halted flag
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        PCSrc,
  input  logic        Jmp,
  input  logic        JAL,
  input  logic        JR,
  input  logic        HALT,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] pc4,
  output logic        commit,
  output logic        halt
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] instr_nxt;
  logic            halt_nxt;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] next_pc;

  // Sequential PC and its derived addresses; arithmetic wraps modulo 2^32.
  assign pc4        = pc + XLEN'(4);
  assign imemaddr   = pc;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Next-PC select for non-memory instructions: JR > J/JAL > taken branch.
  always_comb begin
    next_pc = pc4;
    if (JR) begin
      next_pc = rs_data & ALIGN_MASK;
    end else if (Jmp || JAL) begin
      next_pc = {pc4[31:28], imm26, 2'b00};
    end else if (PCSrc) begin
      next_pc = pc4 + branch_off;
    end
  end

  // State, PC, instruction and halt registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= FETCH;
      pc    <= PC_INIT & ALIGN_MASK;
      Instr <= '0;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      Instr <= instr_nxt;
      halt  <= halt_nxt;
    end
  end

  // Next-state and request/commit decode.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = Instr;
    halt_nxt    = halt;
    imemREN     = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    instr_valid = 1'b0;
    commit      = 1'b0;

    unique case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          instr_nxt = imemload;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (HALT) begin
          halt_nxt  = 1'b1;
          state_nxt = HALTED;
        end else if (MemRd || MemWr) begin
          state_nxt = MEM;
        end else begin
          commit    = 1'b1;
          pc_nxt    = next_pc;
          state_nxt = FETCH;
        end
      end
      MEM: begin
        instr_valid = 1'b1;
        dmemREN     = MemRd;
        dmemWEN     = MemWr;
        if (dhit) begin
          commit    = 1'b1;
          pc_nxt    = pc4;
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        halt_nxt = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of single-instruction records
// (control inputs plus expected PC/PC+4/next-PC), a scoreboard of expected
// fetch addresses, and hand sequences for memory, halt and reset cases.
module tb_fetch_unit;

  logic        clk;
  logic        n_rst;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic        PCSrc, Jmp, JAL, JR, HALT, MemRd, MemWr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN, dmemWEN;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] pc4;
  logic        commit;
  logic        halt;

  fetch_unit #(.PC_INIT(32'h0000_0100)) dut (
    .clk(clk), .n_rst(n_rst), .ihit(ihit), .imemload(imemload), .dhit(dhit),
    .PCSrc(PCSrc), .Jmp(Jmp), .JAL(JAL), .JR(JR), .HALT(HALT),
    .MemRd(MemRd), .MemWr(MemWr), .imm16(imm16), .imm26(imm26),
    .rs_data(rs_data), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .Instr(Instr),
    .instr_valid(instr_valid), .pc4(pc4), .commit(commit), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          waits;
    logic [31:0] word;
    logic        pcsrc, jmp, jal, jr;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic [31:0] addr;
    logic [31:0] p4;
    logic [31:0] nxt;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] exp_q [$];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    PCSrc = 0; Jmp = 0; JAL = 0; JR = 0; HALT = 0; MemRd = 0; MemWr = 0;
    imm16 = '0; imm26 = '0; rs_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the expected fetch address and compare once back in FETCH.
  task automatic sb_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, imemaddr);
    end else begin
      e = exp_q.pop_front();
      chk(name, imemaddr, e);
    end
  endtask

  // Fetch a word at the current PC with immediate ihit; ends in EXEC.
  task automatic fetch_word(input logic [31:0] word, input logic [31:0] addr);
    ihit = 1; imemload = word; dhit = 0;
    #1;
    chk("fetch_addr", imemaddr, addr);
    chk("fetch_ren", 32'(imemREN), 32'd1);
    tick();
    ihit = 0;
  endtask

  task automatic run_rec(input vec_t r, input int idx);
    ihit = 0; dhit = 1; imemload = 32'hDEAD_BEEF; clear_ctrl();
    for (int w = 0; w < r.waits; w++) begin
      #1;
      chk($sformatf("v%0d_wait_addr", idx), imemaddr, r.addr);
      chk($sformatf("v%0d_wait_valid", idx), 32'(instr_valid), 32'd0);
      tick();
    end
    ihit = 1; imemload = r.word; dhit = 0;
    #1;
    chk($sformatf("v%0d_addr", idx), imemaddr, r.addr);
    tick();
    // EXEC: a stray ihit with another word must be ignored.
    ihit = 1; imemload = ~r.word;
    PCSrc = r.pcsrc; Jmp = r.jmp; JAL = r.jal; JR = r.jr;
    imm16 = r.imm16; imm26 = r.imm26; rs_data = r.rs;
    #1;
    chk($sformatf("v%0d_instr", idx), Instr, r.word);
    chk($sformatf("v%0d_valid", idx), 32'(instr_valid), 32'd1);
    chk($sformatf("v%0d_commit", idx), 32'(commit), 32'd1);
    chk($sformatf("v%0d_pc4", idx), pc4, r.p4);
    chk($sformatf("v%0d_addr_hold", idx), imemaddr, r.addr);
    exp_q.push_back(r.nxt);
    tick();
    ihit = 0; clear_ctrl();
    #1;
    chk($sformatf("v%0d_instr_kept", idx), Instr, r.word);
    sb_check($sformatf("v%0d_next_pc", idx));
  endtask

  // LW/SW: fetch, EXEC, then MEM with dhit after 'dly' cycles.
  task automatic mem_op(input logic rd, input logic wr, input int dly,
                        input logic [31:0] addr, input string nm);
    int req_cycles;
    logic [31:0] word;
    word = rd ? 32'h8C22_0000 : 32'hAC22_0004;
    req_cycles = 0;
    fetch_word(word, addr);
    MemRd = rd; MemWr = wr;
    #1;
    chk({nm, "_exec_commit"}, 32'(commit), 32'd0);
    chk({nm, "_exec_noreq"}, 32'({dmemREN, dmemWEN}), 32'd0);
    exp_q.push_back(addr + 32'd4);
    tick();
    for (int k = 0; k <= dly; k++) begin
      dhit = (k == dly); ihit = 1;
      #1;
      if (dmemREN | dmemWEN) req_cycles++;
      chk($sformatf("%s_ren_%0d", nm, k), 32'(dmemREN), 32'(rd));
      chk($sformatf("%s_wen_%0d", nm, k), 32'(dmemWEN), 32'(wr));
      chk($sformatf("%s_commit_%0d", nm, k), 32'(commit), 32'(k == dly));
      chk($sformatf("%s_instr_%0d", nm, k), Instr, word);
      tick();
    end
    dhit = 0; ihit = 0; clear_ctrl();
    #1;
    chk({nm, "_req_cycles"}, 32'(req_cycles), 32'(dly + 1));
    sb_check({nm, "_next_pc"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    n_rst = 0; ihit = 0; dhit = 0; imemload = '0; clear_ctrl();

    //            waits word          pcsrc jmp jal jr imm16     imm26         rs            addr          p4            nxt
    tbl[0]  = '{0, 32'h012A_4020, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0,         32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    tbl[1]  = '{5, 32'h012A_4022, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0,         32'h0000_0104, 32'h0000_0108, 32'h0000_0108};
    tbl[2]  = '{0, 32'h0120_0008, 0, 0, 0, 1, 16'h0000, 26'h0000000, 32'h0000_0043, 32'h0000_0108, 32'h0000_010C, 32'h0000_0040};
    tbl[3]  = '{1, 32'h1000_FFFF, 1, 0, 0, 0, 16'hFFFF, 26'h0000000, 32'h0,         32'h0000_0040, 32'h0000_0044, 32'h0000_0040};
    tbl[4]  = '{2, 32'h1400_FFFF, 0, 0, 0, 0, 16'hFFFF, 26'h0000000, 32'h0,         32'h0000_0040, 32'h0000_0044, 32'h0000_0044};
    tbl[5]  = '{0, 32'h1000_0010, 1, 0, 0, 0, 16'h0010, 26'h0000000, 32'h0,         32'h0000_0044, 32'h0000_0048, 32'h0000_0088};
    tbl[6]  = '{0, 32'h0120_0008, 0, 0, 0, 1, 16'h0000, 26'h0000000, 32'hF000_0011, 32'h0000_0088, 32'h0000_008C, 32'hF000_0010};
    tbl[7]  = '{0, 32'h0800_0010, 0, 1, 0, 0, 16'h0000, 26'h0000010, 32'h0,         32'hF000_0010, 32'hF000_0014, 32'hF000_0040};
    tbl[8]  = '{0, 32'h0BFF_FFFF, 0, 1, 0, 1, 16'h0000, 26'h3FFFFFF, 32'h0000_1237, 32'hF000_0040, 32'hF000_0044, 32'h0000_1234};
    tbl[9]  = '{0, 32'h0C00_0100, 0, 0, 1, 0, 16'h0000, 26'h0000100, 32'h0,         32'h0000_1234, 32'h0000_1238, 32'h0000_0400};
    tbl[10] = '{0, 32'h0120_0008, 0, 0, 0, 1, 16'h0000, 26'h0000000, 32'hFFFF_FFFF, 32'h0000_0400, 32'h0000_0404, 32'hFFFF_FFFC};
    tbl[11] = '{0, 32'h012A_4020, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    tbl[12] = '{0, 32'h0120_0008, 0, 0, 0, 1, 16'h0000, 26'h0000000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFC};
    tbl[13] = '{0, 32'h1000_0004, 1, 0, 0, 0, 16'h0004, 26'h0000000, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010};
    tbl[14] = '{0, 32'h0C00_0020, 1, 0, 1, 0, 16'h0008, 26'h0000020, 32'h0,         32'h0000_0010, 32'h0000_0014, 32'h0000_0080};
    tbl[15] = '{0, 32'h0120_0008, 0, 0, 0, 1, 16'h0000, 26'h0000000, 32'h0000_0200, 32'h0000_0080, 32'h0000_0084, 32'h0000_0200};

    // Reset state while n_rst is held low.
    #12;
    chk("rst_imemREN", 32'(imemREN), 32'd1);
    chk("rst_imemaddr", imemaddr, 32'h0000_0100);
    chk("rst_dmem", 32'({dmemREN, dmemWEN}), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    tick();
    n_rst = 1;
    #1;

    for (int i = 0; i < 16; i++) run_rec(tbl[i], i);

    // LW at 0x200 with dhit three cycles late, then SW with immediate dhit.
    mem_op(1'b1, 1'b0, 3, 32'h0000_0200, "lw");
    mem_op(1'b0, 1'b1, 0, 32'h0000_0204, "sw");

    // HALT at 0x208: requests drop, stray hits are ignored.
    fetch_word(32'hFFFF_FFFF, 32'h0000_0208);
    HALT = 1;
    #1;
    chk("halt_exec_commit", 32'(commit), 32'd0);
    tick();
    clear_ctrl();
    #1;
    chk("halt_flag", 32'(halt), 32'd1);
    chk("halt_reqs", 32'({imemREN, dmemREN, dmemWEN}), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      ihit = 1; dhit = 1; imemload = 32'h1234_5678; MemRd = 1; MemWr = 1;
      tick();
      #1;
      chk($sformatf("halted_%0d_flag", k), 32'(halt), 32'd1);
      chk($sformatf("halted_%0d_reqs", k), 32'({imemREN, dmemREN, dmemWEN, commit}), 32'd0);
      chk($sformatf("halted_%0d_addr", k), imemaddr, 32'h0000_0208);
    end
    ihit = 0; dhit = 0; clear_ctrl();
    n_rst = 0;
    #1;
    chk("halt_rst_flag", 32'(halt), 32'd0);
    chk("halt_rst_ren", 32'(imemREN), 32'd1);
    chk("halt_rst_addr", imemaddr, 32'h0000_0100);
    tick();
    n_rst = 1;
    #1;

    // Reset during a pending store aborts it.
    fetch_word(32'hAC22_0008, 32'h0000_0100);
    MemWr = 1;
    tick();
    #1;
    chk("abort_wen_before", 32'(dmemWEN), 32'd1);
    n_rst = 0;
    #1;
    chk("abort_wen", 32'(dmemWEN), 32'd0);
    chk("abort_commit", 32'(commit), 32'd0);
    chk("abort_addr", imemaddr, 32'h0000_0100);
    tick();
    clear_ctrl();
    n_rst = 1;
    tick();
    #1;
    chk("abort_fetch_ren", 32'(imemREN), 32'd1);
    chk("abort_fetch_addr", imemaddr, 32'h0000_0100);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
